// File: rtl/rggen_trigger_pkg.sv
// Shared definitions for the rggen trigger-to-handshake converter.
//   state_e          : per-bit handshake state (IDLE / REQ / RELEASE)
//   next_state()     : next-state function for one channel
//   is_busy_trigger(): a trigger that arrives while a handshake is still running
package rggen_trigger_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'b00,
    STATE_REQ     = 2'b01,
    STATE_RELEASE = 2'b10
  } state_e;

  // A trigger is only accepted from IDLE, or from RELEASE in the cycle the
  // synchronized ack falls (back-to-back). Any other trigger is "busy".
  function automatic logic is_busy_trigger(state_e st, logic trigger, logic ack_s);
    return trigger && ((st == STATE_REQ) || ((st == STATE_RELEASE) && ack_s));
  endfunction

  // queued is the one-deep pending trigger (tie to 0 when no queue exists).
  function automatic state_e next_state(state_e st, logic trigger, logic ack_s,
                                        logic queued);
    state_e nxt;
    nxt = st;
    case (st)
      STATE_IDLE:    if (trigger) nxt = STATE_REQ;
      STATE_REQ:     if (ack_s) nxt = STATE_RELEASE;
      STATE_RELEASE: if (!ack_s) nxt = (trigger || queued) ? STATE_REQ : STATE_IDLE;
      default:       nxt = STATE_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rggen_trigger_handshake_bit.sv
// One trigger channel: ack synchronizer, 3-state four-phase handshake FSM,
// sticky overflow flag and (optionally) a one-deep trigger queue.
// Optional feature macro: RGGEN_TRIGGER_HANDSHAKE_QUEUE_EN
//   defined   -> a busy trigger is queued; a busy trigger while queued overflows
//   undefined -> a busy trigger is dropped and sets the overflow flag
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_trigger           single-cycle trigger pulse
//   o_req / i_ack       four-phase handshake toward user logic
//   o_busy              1 while the channel is not idle (or has a queued trigger)
//   o_overflow          sticky lost-trigger flag, cleared by i_overflow_clear
module rggen_trigger_handshake_bit
  import rggen_trigger_pkg::*;
#(
  parameter int ACK_SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_trigger,
  output logic o_req,
  input  logic i_ack,
  output logic o_busy,
  output logic o_overflow,
  input  logic i_overflow_clear
);

  logic   ack_s;
  state_e state;
  state_e state_next;
  logic   busy_trigger;
  logic   overflow;
  logic   overflow_next;
  logic   queued;
  logic   queued_next;
  logic   req_q;
  logic   busy_q;

  // ack synchronizer stages
  if (ACK_SYNC_STAGES == 0) begin : g_ack_direct
    assign ack_s = i_ack;
  end else begin : g_ack_sync
    logic [ACK_SYNC_STAGES-1:0] ack_sync_p0;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ack_sync_p0 <= '0;
      end else begin
        ack_sync_p0[0] <= i_ack;
        for (int i = 1; i < ACK_SYNC_STAGES; i++) begin
          ack_sync_p0[i] <= ack_sync_p0[i-1];
        end
      end
    end
    assign ack_s = ack_sync_p0[ACK_SYNC_STAGES-1];
  end

`ifdef RGGEN_TRIGGER_HANDSHAKE_QUEUE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) queued <= 1'b0;
    else       queued <= queued_next;
  end
`else
  assign queued = 1'b0;
`endif

  always_comb begin
    state_next    = next_state(state, i_trigger, ack_s, queued);
    busy_trigger  = is_busy_trigger(state, i_trigger, ack_s);
    queued_next   = queued;
`ifdef RGGEN_TRIGGER_HANDSHAKE_QUEUE_EN
    // The queued trigger is consumed when RELEASE completes; a fresh trigger
    // in that same cycle takes the freed slot instead of being lost.
    if ((state == STATE_RELEASE) && !ack_s && queued) begin
      queued_next = i_trigger;
    end else if (busy_trigger) begin
      queued_next = 1'b1;
    end
    overflow_next = (busy_trigger && queued) || (overflow && !i_overflow_clear);
`else
    overflow_next = busy_trigger || (overflow && !i_overflow_clear);
`endif
  end

  // state and registered outputs; outputs are decoded from next values so
  // they change at the same edge as the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= STATE_IDLE;
      overflow <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      overflow <= overflow_next;
      req_q    <= (state_next == STATE_REQ);
      busy_q   <= (state_next != STATE_IDLE) || queued_next;
    end
  end

  assign o_req      = req_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow;

endmodule

// File: rtl/rggen_trigger_handshake.sv
// Converts rggen write-trigger pulses into per-bit four-phase req/ack
// handshakes. Each of the WIDTH channels is independent.
// Optional feature macro: RGGEN_TRIGGER_HANDSHAKE_QUEUE_EN (one-deep trigger
// queue per channel; see rggen_trigger_handshake_bit).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_trigger[W]        trigger pulses from the bit field's o_trigger
//   o_req[W] / i_ack[W] handshake toward user logic (i_ack may be async)
//   o_busy[W]           per-bit busy, for the bit field's i_value
//   o_overflow[W]       sticky lost-trigger flags
//   i_overflow_clear[W] per-bit overflow clear
module rggen_trigger_handshake
  import rggen_trigger_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int ACK_SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_trigger,
  output logic [WIDTH-1:0] o_req,
  input  logic [WIDTH-1:0] i_ack,
  output logic [WIDTH-1:0] o_busy,
  output logic [WIDTH-1:0] o_overflow,
  input  logic [WIDTH-1:0] i_overflow_clear
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    rggen_trigger_handshake_bit #(
      .ACK_SYNC_STAGES (ACK_SYNC_STAGES)
    ) u_bit (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_trigger        (i_trigger[g]),
      .o_req            (o_req[g]),
      .i_ack            (i_ack[g]),
      .o_busy           (o_busy[g]),
      .o_overflow       (o_overflow[g]),
      .i_overflow_clear (i_overflow_clear[g])
    );
  end

endmodule

// File: tb/tb_rggen_trigger_handshake.sv
module tb_rggen_trigger_handshake;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_trigger;
  logic [7:0] o_req;
  logic [7:0] i_ack;
  logic [7:0] o_busy;
  logic [7:0] o_overflow;
  logic [7:0] i_overflow_clear;

  int n_cmp = 0;
  int n_err = 0;

  rggen_trigger_handshake #(
    .WIDTH           (8),
    .ACK_SYNC_STAGES (2)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_trigger        (i_trigger),
    .o_req            (o_req),
    .i_ack            (i_ack),
    .o_busy           (o_busy),
    .o_overflow       (o_overflow),
    .i_overflow_clear (i_overflow_clear)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_trigger = '0; i_ack = 8'hFF; i_overflow_clear = '0;
    #1;
    // reset / idle
    tick(3);
    chk("rst_req", o_req, 8'h00);
    chk("rst_busy", o_busy, 8'h00);
    chk("rst_ovf", o_overflow, 8'h00);
    i_rst = 1'b0; i_ack = 8'h00;
    tick(4);
    chk("idle_req", o_req, 8'h00);
    chk("idle_busy", o_busy, 8'h00);
    chk("idle_ovf", o_overflow, 8'h00);

    // basic handshake on bit 0
    i_trigger = 8'h01; tick; i_trigger = 8'h00;
    chk("b0_req", o_req, 8'h01);
    chk("b0_busy", o_busy, 8'h01);
    i_ack = 8'h01; tick(2);
    chk("b0_req_hold", o_req, 8'h01);
    tick;
    chk("b0_req_drop", o_req, 8'h00);
    chk("b0_busy_rel", o_busy, 8'h01);
    i_ack = 8'h00; tick(2);
    chk("b0_busy_hold", o_busy, 8'h01);
    tick;
    chk("b0_busy_drop", o_busy, 8'h00);

`ifndef RGGEN_TRIGGER_HANDSHAKE_QUEUE_EN
    // overflow on bit 3
    i_trigger = 8'h08; tick; i_trigger = 8'h00;
    chk("b3_req", o_req, 8'h08);
    i_trigger = 8'h08; tick; i_trigger = 8'h00;
    chk("b3_ovf", o_overflow, 8'h08);
    chk("b3_req_one", o_req, 8'h08);
    i_trigger = 8'h08; i_overflow_clear = 8'h08; tick;
    i_trigger = 8'h00; i_overflow_clear = 8'h00;
    chk("b3_set_wins", o_overflow, 8'h08);
    i_overflow_clear = 8'h08; tick; i_overflow_clear = 8'h00;
    chk("b3_clear", o_overflow, 8'h00);
    i_ack = 8'h08; tick(3);
    chk("b3_req_drop", o_req, 8'h00);
    i_ack = 8'h00; tick(3);
    chk("b3_idle", o_busy, 8'h00);
    tick(4);
    chk("b3_no_second_req", o_req, 8'h00);
`else
    // queue on bit 2
    i_trigger = 8'h04; tick; i_trigger = 8'h00;
    chk("q_req1", o_req, 8'h04);
    i_trigger = 8'h04; tick; i_trigger = 8'h00;
    chk("q_queued_no_ovf", o_overflow, 8'h00);
    chk("q_busy", o_busy, 8'h04);
    i_trigger = 8'h04; tick; i_trigger = 8'h00;
    chk("q_ovf", o_overflow, 8'h04);
    i_ack = 8'h04; tick(3);
    chk("q_req1_drop", o_req, 8'h00);
    chk("q_busy_rel", o_busy, 8'h04);
    i_ack = 8'h00; tick(3);
    chk("q_req2", o_req, 8'h04);
    i_ack = 8'h04; tick(3);
    chk("q_req2_drop", o_req, 8'h00);
    i_ack = 8'h00; tick(3);
    chk("q_idle", o_busy, 8'h00);
    tick(4);
    chk("q_no_third_req", o_req, 8'h00);
    i_overflow_clear = 8'h04; tick; i_overflow_clear = 8'h00;
    chk("q_clear", o_overflow, 8'h00);
`endif

    // back-to-back on bit 5
    i_trigger = 8'h20; tick; i_trigger = 8'h00;
    chk("b5_req", o_req, 8'h20);
    i_ack = 8'h20; tick(3);
    chk("b5_rel", o_req, 8'h00);
    i_ack = 8'h00; tick(2);
    // synchronized ack is low during this cycle: trigger is accepted
    i_trigger = 8'h20; tick; i_trigger = 8'h00;
    chk("b5_b2b_req", o_req, 8'h20);
    chk("b5_b2b_ovf", o_overflow, 8'h00);
    i_ack = 8'h20; tick(3);
    i_ack = 8'h00; tick(3);
    chk("b5_idle", o_busy, 8'h00);

    // reset in the middle of a handshake
    i_trigger = 8'hA5; tick;
    chk("mr_req", o_req, 8'hA5);
    tick; i_trigger = 8'h00;  // busy trigger: queues (or overflows)
    i_rst = 1'b1; tick;
    chk("mr_req_rst", o_req, 8'h00);
    chk("mr_busy_rst", o_busy, 8'h00);
    chk("mr_ovf_rst", o_overflow, 8'h00);
    i_rst = 1'b0; tick(6);
    chk("mr_no_resume", o_req, 8'h00);
    chk("mr_idle", o_busy, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
